// File: rtl/credit_rr_output_sched_pkg.sv
// Shared dynamic-network constants: FSM encoding, default credit buffer sizing,
// and flit/length field widths used by the output schedulers.
package credit_rr_output_sched_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  // Every dynamic-node credit counter in the network assumes this depth.
  localparam int DYN_BUFFER_SIZE = 4;
  localparam int DYN_BUFFER_BITS = 3;

  localparam int NET_LEN_BITS   = 8;
  localparam int NET_DATA_WIDTH = 64;

endpackage

// File: rtl/credit_rr_output_sched_rr_pick.sv
// Rotate-priority picker: first asserted request at or above ptr, wrapping.
// Purely combinational, zero latency; no flow control of its own.
module rr_pick
  import credit_rr_output_sched_pkg::*;
#(
  parameter int NUM_REQ  = 5,
  parameter int REQ_BITS = 3
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [REQ_BITS-1:0] ptr,
  output logic [REQ_BITS-1:0] winner,
  output logic                any_vld
);

  localparam logic [REQ_BITS:0] NREQ_W = (REQ_BITS+1)'(NUM_REQ);

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic [REQ_BITS:0]    off;
  logic [REQ_BITS:0]    sum;

  // Doubling the vector turns the wrap-around search into a plain shift.
  assign req_dbl = {req, req} >> ptr;
  assign req_rot = req_dbl[NUM_REQ-1:0];

  always_comb begin
    any_vld = 1'b0;
    off     = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (req_rot[j]) begin
        any_vld = 1'b1;
        off     = (REQ_BITS+1)'(j);
      end
    end
    sum = {1'b0, ptr} + off;
    if (sum >= NREQ_W) begin
      sum = sum - NREQ_W;
    end
    winner = sum[REQ_BITS-1:0];
  end

endmodule

// File: rtl/credit_rr_output_sched.sv
// Round-robin, packet-granular owner of one credit-flow-controlled output link.
// 1-cycle arbitration; sends only while credit!=0, holds grant through stalls.
module credit_rr_output_sched
  import credit_rr_output_sched_pkg::*;
#(
  parameter int NUM_REQ     = 5,
  parameter int REQ_BITS    = 3,
  parameter int DATA_WIDTH  = NET_DATA_WIDTH,
  parameter int LEN_BITS    = NET_LEN_BITS,
  parameter int BUFFER_SIZE = DYN_BUFFER_SIZE,
  parameter int BUFFER_BITS = DYN_BUFFER_BITS
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_i,
  input  logic [NUM_REQ*LEN_BITS-1:0]    len_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  data_i,
  input  logic                           yummy_i,
  output logic [NUM_REQ-1:0]             gnt_o,
  output logic [NUM_REQ-1:0]             pop_o,
  output logic                           valid_o,
  output logic [DATA_WIDTH-1:0]          data_o,
  output logic [BUFFER_BITS-1:0]         credit_o,
  output logic                           overflow_err_o
);

  localparam logic [BUFFER_BITS-1:0] CREDIT_FULL = BUFFER_BITS'(BUFFER_SIZE);
  localparam logic [REQ_BITS-1:0]    LAST_REQ    = REQ_BITS'(NUM_REQ - 1);

  logic [0:0]             state;
  logic [REQ_BITS-1:0]    owner;
  logic [REQ_BITS-1:0]    rr_ptr;
  logic [LEN_BITS-1:0]    remaining;
  logic [BUFFER_BITS-1:0] credit;
  logic                   yummy_f;

  logic [REQ_BITS-1:0]    pick_idx;
  logic                   pick_vld;
  logic [LEN_BITS-1:0]    pick_len;
  logic [DATA_WIDTH-1:0]  owner_dat;
  logic                   fire;

  rr_pick #(
    .NUM_REQ  (NUM_REQ),
    .REQ_BITS (REQ_BITS)
  ) u_rr_pick (
    .req     (req_i),
    .ptr     (rr_ptr),
    .winner  (pick_idx),
    .any_vld (pick_vld)
  );

  // gnt_o is one-hot on the owner, so masking with it equals req_i[owner].
  assign fire = rst_n & (state == ST_BUSY) & (|(req_i & gnt_o)) & (credit != '0);

  always_comb begin
    owner_dat = '0;
    pick_len  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_o[i]) begin
        owner_dat = data_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
      if (pick_idx == REQ_BITS'(i)) begin
        pick_len = len_i[i*LEN_BITS +: LEN_BITS];
      end
    end
  end

  assign valid_o  = fire;
  assign pop_o    = fire ? gnt_o : '0;
  assign data_o   = fire ? owner_dat : '0;
  assign credit_o = credit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      owner     <= '0;
      gnt_o     <= '0;
      rr_ptr    <= '0;
      remaining <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_vld) begin
            state     <= ST_BUSY;
            owner     <= pick_idx;
            gnt_o     <= NUM_REQ'(1'b1) << pick_idx;
            remaining <= pick_len;
          end
        end
        default: begin
          if (fire) begin
            if (remaining == '0) begin
              state  <= ST_IDLE;
              gnt_o  <= '0;
              rr_ptr <= (owner == LAST_REQ) ? '0 : owner + 1'b1;
            end else begin
              remaining <= remaining - 1'b1;
            end
          end
        end
      endcase
    end
  end

  // A return arriving with the counter already full signals a protocol bug downstream.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      credit         <= CREDIT_FULL;
      yummy_f        <= 1'b0;
      overflow_err_o <= 1'b0;
    end else begin
      yummy_f <= yummy_i;
      if (fire && !yummy_f) begin
        credit <= credit - 1'b1;
      end else if (!fire && yummy_f) begin
        if (credit == CREDIT_FULL) begin
          overflow_err_o <= 1'b1;
        end else begin
          credit <= credit + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_credit_rr_output_sched.sv
// Directed bench for credit_rr_output_sched; inputs change and outputs are
// sampled 1-2 time units after each rising edge.
module tb_credit_rr_output_sched;

  localparam int NUM_REQ     = 5;
  localparam int REQ_BITS    = 3;
  localparam int DATA_WIDTH  = 64;
  localparam int LEN_BITS    = 8;
  localparam int BUFFER_SIZE = 4;
  localparam int BUFFER_BITS = 3;

  logic                          clk = 1'b0;
  logic                          rst_n;
  logic [NUM_REQ-1:0]            req_i;
  logic [NUM_REQ*LEN_BITS-1:0]   len_i;
  logic [NUM_REQ*DATA_WIDTH-1:0] data_i;
  logic                          yummy_i;
  logic [NUM_REQ-1:0]            gnt_o;
  logic [NUM_REQ-1:0]            pop_o;
  logic                          valid_o;
  logic [DATA_WIDTH-1:0]         data_o;
  logic [BUFFER_BITS-1:0]        credit_o;
  logic                          overflow_err_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_WIDTH-1:0] dat [NUM_REQ];

  credit_rr_output_sched #(
    .NUM_REQ     (NUM_REQ),
    .REQ_BITS    (REQ_BITS),
    .DATA_WIDTH  (DATA_WIDTH),
    .LEN_BITS    (LEN_BITS),
    .BUFFER_SIZE (BUFFER_SIZE),
    .BUFFER_BITS (BUFFER_BITS)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_i          (req_i),
    .len_i          (len_i),
    .data_i         (data_i),
    .yummy_i        (yummy_i),
    .gnt_o          (gnt_o),
    .pop_o          (pop_o),
    .valid_o        (valid_o),
    .data_o         (data_o),
    .credit_o       (credit_o),
    .overflow_err_o (overflow_err_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs set after this take effect next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_len(input int idx, input logic [LEN_BITS-1:0] v);
    len_i[idx*LEN_BITS +: LEN_BITS] = v;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    req_i   = '0;
    yummy_i = 1'b0;
    len_i   = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NUM_REQ; i++) begin
      dat[i] = 64'h0101_0101_0101_0101 * 64'(i + 1);
      data_i[i*DATA_WIDTH +: DATA_WIDTH] = dat[i];
    end

    // Reset values
    do_reset();
    settle();
    check_eq("rst_gnt", gnt_o, 0);
    check_eq("rst_valid", valid_o, 0);
    check_eq("rst_pop", pop_o, 0);
    check_eq("rst_data", data_o, 0);
    check_eq("rst_credit", credit_o, 4);
    check_eq("rst_ovf", overflow_err_o, 0);

    // Single packet, len=2 -> 3 flits, credit 4 -> 1
    req_i = 5'b00001;
    set_len(0, 8'd2);
    settle();
    check_eq("p1_idle_valid", valid_o, 0);
    tick(); settle();
    check_eq("p1_gnt", gnt_o, 5'b00001);
    check_eq("p1_f1_valid", valid_o, 1);
    check_eq("p1_f1_pop", pop_o, 5'b00001);
    check_eq("p1_f1_data", data_o, dat[0]);
    check_eq("p1_f1_credit", credit_o, 4);
    tick(); settle();
    check_eq("p1_f2_valid", valid_o, 1);
    check_eq("p1_f2_credit", credit_o, 3);
    tick(); settle();
    check_eq("p1_f3_valid", valid_o, 1);
    check_eq("p1_f3_credit", credit_o, 2);
    tick();
    req_i = 5'b00011;
    set_len(0, 8'd0);
    set_len(1, 8'd0);
    settle();
    check_eq("p1_end_gnt", gnt_o, 0);
    check_eq("p1_end_valid", valid_o, 0);
    check_eq("p1_end_credit", credit_o, 1);
    // rr_ptr=1 now, so requester 1 beats requester 0
    tick(); settle();
    check_eq("p1_rrptr_gnt", gnt_o, 5'b00010);
    check_eq("p1_rrptr_data", data_o, dat[1]);
    tick(); settle();
    check_eq("p1_last_gnt", gnt_o, 0);
    check_eq("p1_last_credit", credit_o, 0);

    // Credit stall: req 2, len=5 -> 6 flits with only 4 credits
    do_reset();
    req_i = 5'b00100;
    set_len(2, 8'd5);
    tick(); settle();
    check_eq("cs_gnt", gnt_o, 5'b00100);
    for (int k = 0; k < 4; k++) begin
      check_eq("cs_valid", valid_o, 1);
      check_eq("cs_credit", credit_o, 64'(4 - k));
      tick(); settle();
    end
    check_eq("cs_stall_valid", valid_o, 0);
    check_eq("cs_stall_gnt", gnt_o, 5'b00100);
    check_eq("cs_stall_credit", credit_o, 0);
    tick(); settle();
    check_eq("cs_stall2_valid", valid_o, 0);
    yummy_i = 1'b1;
    tick();
    yummy_i = 1'b0;
    settle();
    check_eq("cs_y1_wait_valid", valid_o, 0);
    tick(); settle();
    check_eq("cs_f5_valid", valid_o, 1);
    check_eq("cs_f5_credit", credit_o, 1);
    tick(); settle();
    check_eq("cs_after5_valid", valid_o, 0);
    check_eq("cs_after5_gnt", gnt_o, 5'b00100);
    yummy_i = 1'b1;
    tick();
    yummy_i = 1'b0;
    settle();
    check_eq("cs_y2_wait_gnt", gnt_o, 5'b00100);
    tick(); settle();
    check_eq("cs_f6_valid", valid_o, 1);
    tick(); settle();
    check_eq("cs_end_gnt", gnt_o, 0);
    check_eq("cs_end_valid", valid_o, 0);

    // Round-robin fairness: all requesting, single-flit packets, credit returned
    do_reset();
    req_i = 5'b11111;
    settle();
    check_eq("rr_start_gnt", gnt_o, 0);
    for (int k = 0; k < 6; k++) begin
      tick();
      yummy_i = 1'b1;
      settle();
      check_eq("rr_gnt", gnt_o, 64'(5'b00001 << (k % 5)));
      check_eq("rr_data", data_o, dat[k % 5]);
      check_eq("rr_credit_busy", credit_o, 4);
      tick();
      yummy_i = 1'b0;
      settle();
      check_eq("rr_idle_gnt", gnt_o, 0);
      check_eq("rr_idle_credit", credit_o, 3);
    end
    req_i = '0;

    // Simultaneous fire and credit return at credit=1
    do_reset();
    req_i = 5'b00001;
    set_len(0, 8'd4);
    tick(); settle();
    check_eq("sf_c4", credit_o, 4);
    tick(); settle();
    check_eq("sf_c3", credit_o, 3);
    tick();
    yummy_i = 1'b1;
    settle();
    check_eq("sf_c2", credit_o, 2);
    tick();
    yummy_i = 1'b0;
    settle();
    check_eq("sf_c1_valid", valid_o, 1);
    check_eq("sf_c1", credit_o, 1);
    tick(); settle();
    check_eq("sf_hold_c1", credit_o, 1);
    check_eq("sf_hold_valid", valid_o, 1);
    tick(); settle();
    check_eq("sf_c0", credit_o, 0);
    check_eq("sf_end_gnt", gnt_o, 0);

    // Overflow: return while full
    do_reset();
    yummy_i = 1'b1;
    tick();
    yummy_i = 1'b0;
    settle();
    check_eq("ov_pre_flag", overflow_err_o, 0);
    tick(); settle();
    check_eq("ov_flag", overflow_err_o, 1);
    check_eq("ov_credit", credit_o, 4);
    tick(); tick(); settle();
    check_eq("ov_sticky", overflow_err_o, 1);
    rst_n = 1'b0;
    tick(); settle();
    check_eq("ov_cleared", overflow_err_o, 0);

    // Reset mid-packet after moving rr_ptr to 3
    do_reset();
    req_i = 5'b00100;
    set_len(2, 8'd0);
    tick(); settle();
    check_eq("rm_pre_gnt", gnt_o, 5'b00100);
    tick();
    req_i = 5'b00001;
    set_len(0, 8'd3);
    tick(); settle();
    check_eq("rm_gnt0", gnt_o, 5'b00001);
    tick();
    rst_n = 1'b0;
    settle();
    check_eq("rm_rstcyc_valid", valid_o, 0);
    tick();
    rst_n = 1'b1;
    req_i = 5'b01010;
    set_len(1, 8'd0);
    set_len(3, 8'd0);
    settle();
    check_eq("rm_gnt", gnt_o, 0);
    check_eq("rm_valid", valid_o, 0);
    check_eq("rm_credit", credit_o, 4);
    tick(); settle();
    check_eq("rm_winner", gnt_o, 5'b00010);
    check_eq("rm_winner_data", data_o, dat[1]);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
